// File: rtl/block_gen_pkg.sv
// -----------------------------------------------------------------------------
// block_gen_pkg
// Shared definitions for the obstacle-row generator:
//   state_e       - generator FSM states (IDLE, BLOCK, GAP)
//   LFSR_TAPS     - Galois feedback mask for x^16+x^14+x^13+x^11
//   DEFAULT_SEED  - reset seed, also substituted whenever a zero seed is loaded
//   CNT_W         - width of the accepted-block-row counter
// -----------------------------------------------------------------------------
package block_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLOCK = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          CNT_W        = 16;

endpackage

// File: rtl/block_lfsr.sv
// -----------------------------------------------------------------------------
// block_lfsr
// Seedable Galois LFSR that advances only when the downstream consumer takes a
// row. A zero seed would lock the register at zero forever, so it is replaced
// by the default seed.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset (loads SEED)
//   i_load       in   load strobe, takes priority over i_step
//   i_seed       in   seed value for i_load
//   i_step       in   advance one Galois step
//   o_lfsr       out  current register value
//   o_lfsr_next  out  value the register takes on the next step
// -----------------------------------------------------------------------------
module block_lfsr
    import block_gen_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_lfsr,
    output logic [LFSR_W-1:0] o_lfsr_next
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_next;

    assign w_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= (i_seed == '0) ? SEED : i_seed;
        end else if (i_step) begin
            r_lfsr <= w_next;
        end
    end

    assign o_lfsr      = r_lfsr;
    assign o_lfsr_next = w_next;

endmodule

// File: rtl/block_row_generator.sv
// -----------------------------------------------------------------------------
// block_row_generator
// Streams obstacle rows to the playfield scroller: a block row, then a random
// number of empty gap rows, then the next block row, and so on. Every block
// row has at least one open cell and at least one block cell. Rows are handed
// over with valid/ready; all outputs are registered.
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous active-low reset
//   en              in   run enable from the game controller
//   seed_load       in   one-cycle strobe loading seed into the LFSR
//   seed            in   new LFSR seed (zero selects the default seed)
//   row_ready       in   downstream accepts the current row
//   row_valid       out  row_data is valid
//   row_data        out  row pattern, 1 = block cell
//   row_is_block    out  current row is a block row
//   blocks_emitted  out  accepted block rows, wrapping counter
// -----------------------------------------------------------------------------
module block_row_generator
    import block_gen_pkg::*;
#(
    parameter int                ROW_W       = 8,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED,
    parameter int                GAP_MIN     = 1,
    parameter int                GAP_RANGE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              row_ready,
    output logic              row_valid,
    output logic [ROW_W-1:0]  row_data,
    output logic              row_is_block,
    output logic [CNT_W-1:0]  blocks_emitted
);

    // Wide enough for the longest gap, GAP_MIN + 2^GAP_RANGE_W - 1.
    localparam int GAP_CNT_W = $clog2(GAP_MIN + (1 << GAP_RANGE_W)) + 1;

    state_e               r_state;
    logic                 r_row_valid;
    logic [ROW_W-1:0]     r_row_data;
    logic                 r_row_is_block;
    logic [CNT_W-1:0]     r_blocks_emitted;
    logic [GAP_CNT_W-1:0] r_gap_cnt;

    logic                 w_accept;
    logic [LFSR_W-1:0]    w_lfsr;
    logic [LFSR_W-1:0]    w_lfsr_next;
    logic [ROW_W-1:0]     w_raw_cur;
    logic [ROW_W-1:0]     w_raw_next;
    logic [GAP_CNT_W-1:0] w_gap_len;
    logic                 w_unused_lfsr_bits;

    // Force every block row to be both passable and non-empty.
    function automatic logic [ROW_W-1:0] make_pattern(input logic [ROW_W-1:0] raw);
        logic [ROW_W-1:0] pat;
        pat = raw;
        if (&raw) begin
            pat[ROW_W-1] = 1'b0;
        end else if (raw == '0) begin
            pat[0] = 1'b1;
        end
        return pat;
    endfunction

    assign w_accept = r_row_valid & row_ready;

    block_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (LFSR_TAPS)
    ) u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (seed_load),
        .i_seed      (seed),
        .i_step      (w_accept),
        .o_lfsr      (w_lfsr),
        .o_lfsr_next (w_lfsr_next)
    );

    // Low ROW_W bits of the LFSR; rows wider than the LFSR get zero upper bits.
    always_comb begin
        w_raw_cur  = '0;
        w_raw_next = '0;
        for (int i = 0; i < ROW_W; i++) begin
            if (i < LFSR_W) begin
                w_raw_cur[i]  = w_lfsr[i % LFSR_W];
                w_raw_next[i] = w_lfsr_next[i % LFSR_W];
            end
        end
    end

    // Gap length is drawn from the LFSR before it steps for this accept.
    assign w_gap_len = GAP_CNT_W'(GAP_MIN) + GAP_CNT_W'(w_lfsr[LFSR_W-1 -: GAP_RANGE_W]);

    assign w_unused_lfsr_bits = ^{w_lfsr, w_lfsr_next};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_row_valid      <= 1'b0;
            r_row_data       <= '0;
            r_row_is_block   <= 1'b0;
            r_blocks_emitted <= '0;
            r_gap_cnt        <= '0;
        end else if (seed_load) begin
            // Abort whatever row is pending; the counter keeps its history.
            r_state        <= IDLE;
            r_row_valid    <= 1'b0;
            r_row_data     <= '0;
            r_row_is_block <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state        <= BLOCK;
                        r_row_valid    <= 1'b1;
                        r_row_data     <= make_pattern(w_raw_cur);
                        r_row_is_block <= 1'b1;
                    end
                end
                BLOCK: begin
                    // Everything holds under backpressure; en is only
                    // looked at when the row is taken.
                    if (w_accept) begin
                        r_blocks_emitted <= r_blocks_emitted + 1'b1;
                        r_gap_cnt        <= w_gap_len;
                        r_row_data       <= '0;
                        r_row_is_block   <= 1'b0;
                        if (en) begin
                            r_state <= GAP;
                        end else begin
                            r_state     <= IDLE;
                            r_row_valid <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (w_accept) begin
                        if (!en) begin
                            r_state     <= IDLE;
                            r_row_valid <= 1'b0;
                            r_gap_cnt   <= '0;
                        end else if (r_gap_cnt == GAP_CNT_W'(1)) begin
                            // The LFSR steps on this same edge, so the new
                            // block row is built from its next value.
                            r_state        <= BLOCK;
                            r_row_data     <= make_pattern(w_raw_next);
                            r_row_is_block <= 1'b1;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_row_valid <= 1'b0;
                end
            endcase
        end
    end

    assign row_valid      = r_row_valid;
    assign row_data       = r_row_data;
    assign row_is_block   = r_row_is_block;
    assign blocks_emitted = r_blocks_emitted;

endmodule

// File: tb/tb_block_row_generator.sv
// -----------------------------------------------------------------------------
// tb_block_row_generator
// Self-checking bench for block_row_generator (default parameters). Expected
// rows come from a stream model: starting from a seed, the sequence of
// accepted rows is block P(l), then GAP_MIN + l[15:14] zero rows, with the
// LFSR advanced once per accepted row.
// -----------------------------------------------------------------------------
module tb_block_row_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        seed_load;
    logic [15:0] seed;
    logic        row_ready;
    logic        row_valid;
    logic [7:0]  row_data;
    logic        row_is_block;
    logic [15:0] blocks_emitted;

    int checks = 0;
    int fails  = 0;

    logic [7:0] q_data[$];
    bit         q_blk[$];

    always #5 clk = ~clk;

    block_row_generator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .seed_load      (seed_load),
        .seed           (seed),
        .row_ready      (row_ready),
        .row_valid      (row_valid),
        .row_data       (row_data),
        .row_is_block   (row_is_block),
        .blocks_emitted (blocks_emitted)
    );

    function automatic logic [15:0] m_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] m_pat(input logic [15:0] l);
        logic [7:0] r;
        r = l[7:0];
        if (r == 8'hFF) return 8'h7F;
        if (r == 8'h00) return 8'h01;
        return r;
    endfunction

    // Accepted-row stream with en held high, starting from seed s.
    task automatic build_stream(input logic [15:0] s, input int nrows);
        logic [15:0] l;
        int gap;
        q_data.delete();
        q_blk.delete();
        l = s;
        while (q_data.size() < nrows) begin
            q_data.push_back(m_pat(l));
            q_blk.push_back(1'b1);
            gap = 1 + int'(l[15:14]);
            l = m_step(l);
            for (int g = 0; g < gap; g++) begin
                q_data.push_back(8'h00);
                q_blk.push_back(1'b0);
                l = m_step(l);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        en        = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;
        row_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        en = 1'b1;
        row_ready = 1'b1;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        checks++; if (row_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b want=0", row_valid); end
        checks++; if (row_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h want=00", row_data); end
        checks++; if (row_is_block !== 1'b0) begin fails++; $display("FAIL reset_is_block got=%0b want=0", row_is_block); end
        checks++; if (blocks_emitted !== 16'h0000) begin fails++; $display("FAIL reset_count got=%h want=0000", blocks_emitted); end
    endtask

    task automatic test_first_rows;
        do_reset();
        build_stream(16'hACE1, 24);
        en = 1'b1;
        row_ready = 1'b1;
        tick();
        checks++; if (row_valid !== 1'b1) begin fails++; $display("FAIL first_valid got=%0b want=1", row_valid); end
        checks++; if (row_data !== 8'hE1) begin fails++; $display("FAIL first_data got=%h want=e1", row_data); end
        checks++; if (row_is_block !== 1'b1) begin fails++; $display("FAIL first_is_block got=%0b want=1", row_is_block); end
        for (int i = 0; i < 24; i++) begin
            checks++; if (row_valid !== 1'b1) begin fails++; $display("FAIL stream_valid row=%0d got=%0b want=1", i, row_valid); end
            checks++; if (row_data !== q_data[i]) begin fails++; $display("FAIL stream_data row=%0d got=%h want=%h", i, row_data, q_data[i]); end
            checks++; if (row_is_block !== q_blk[i]) begin fails++; $display("FAIL stream_is_block row=%0d got=%0b want=%0b", i, row_is_block, q_blk[i]); end
            if (i == 4) begin
                checks++; if (blocks_emitted !== 16'd1) begin fails++; $display("FAIL first_count got=%0d want=1", blocks_emitted); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int exp_cnt;
        bit r;
        do_reset();
        build_stream(16'hACE1, 500);
        en = 1'b1;
        row_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (row_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cyc=%0d got=%0b want=1", c, row_valid); end
            checks++; if (row_data !== q_data[0]) begin fails++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", c, row_data, q_data[0]); end
            checks++; if (blocks_emitted !== 16'd0) begin fails++; $display("FAIL bp_hold_count cyc=%0d got=%0d want=0", c, blocks_emitted); end
            tick();
        end
        row_ready = 1'b1;
        tick();
        row_ready = 1'b0;
        tick();
        checks++; if (blocks_emitted !== 16'd1) begin fails++; $display("FAIL bp_one_accept got=%0d want=1", blocks_emitted); end
        checks++; if (row_data !== q_data[1] || row_is_block !== q_blk[1]) begin fails++; $display("FAIL bp_after_row got=%h/%0b want=%h/%0b", row_data, row_is_block, q_data[1], q_blk[1]); end
        idx = 1;
        exp_cnt = 1;
        for (int c = 0; c < 300; c++) begin
            r = ($urandom_range(0, 2) != 0);
            row_ready = r;
            checks++; if (row_valid !== 1'b1) begin fails++; $display("FAIL rnd_valid cyc=%0d got=%0b want=1", c, row_valid); end
            checks++; if (row_data !== q_data[idx] || row_is_block !== q_blk[idx]) begin fails++; $display("FAIL rnd_row cyc=%0d got=%h/%0b want=%h/%0b", c, row_data, row_is_block, q_data[idx], q_blk[idx]); end
            checks++; if (blocks_emitted !== 16'(exp_cnt)) begin fails++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, blocks_emitted, exp_cnt); end
            tick();
            if (r) begin
                if (q_blk[idx]) exp_cnt++;
                idx++;
            end
        end
        // Walk forward to a block row, then drop en while it is back-pressured.
        row_ready = 1'b1;
        while (!q_blk[idx]) begin
            tick();
            idx++;
        end
        row_ready = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        checks++; if (row_valid !== 1'b1 || row_is_block !== 1'b1 || row_data !== q_data[idx]) begin fails++; $display("FAIL bp_en_drop_hold got=%0b/%0b/%h want=1/1/%h", row_valid, row_is_block, row_data, q_data[idx]); end
        row_ready = 1'b1;
        tick();
        checks++; if (row_valid !== 1'b0) begin fails++; $display("FAIL bp_en_drop_idle got=%0b want=0", row_valid); end
        checks++; if (blocks_emitted !== 16'(exp_cnt + 1)) begin fails++; $display("FAIL bp_en_drop_count got=%0d want=%0d", blocks_emitted, exp_cnt + 1); end
    endtask

    task automatic test_seed_edges;
        logic [15:0] s_tab[3];
        logic [7:0]  e_tab[3];
        s_tab = '{16'h00FF, 16'h1200, 16'h0000};
        e_tab = '{8'h7F, 8'h01, 8'hE1};
        do_reset();
        row_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en = 1'b0;
            seed = s_tab[k];
            seed_load = 1'b1;
            tick();
            seed_load = 1'b0;
            checks++; if (row_valid !== 1'b0) begin fails++; $display("FAIL seed_idle k=%0d got=%0b want=0", k, row_valid); end
            en = 1'b1;
            tick();
            checks++; if (row_valid !== 1'b1 || row_is_block !== 1'b1) begin fails++; $display("FAIL seed_block k=%0d got=%0b/%0b want=1/1", k, row_valid, row_is_block); end
            checks++; if (row_data !== e_tab[k]) begin fails++; $display("FAIL seed_row k=%0d got=%h want=%h", k, row_data, e_tab[k]); end
        end
    endtask

    task automatic test_en_drop_mid_gap;
        logic [7:0] exp_row;
        do_reset();
        en = 1'b1;
        row_ready = 1'b1;
        tick();
        tick();
        checks++; if (row_valid !== 1'b1 || row_is_block !== 1'b0) begin fails++; $display("FAIL gap_row got=%0b/%0b want=1/0", row_valid, row_is_block); end
        en = 1'b0;
        tick();
        checks++; if (row_valid !== 1'b0) begin fails++; $display("FAIL gap_drop_valid got=%0b want=0", row_valid); end
        tick();
        checks++; if (row_valid !== 1'b0) begin fails++; $display("FAIL gap_drop_stay got=%0b want=0", row_valid); end
        en = 1'b1;
        tick();
        exp_row = m_pat(m_step(m_step(16'hACE1)));
        checks++; if (row_valid !== 1'b1 || row_is_block !== 1'b1) begin fails++; $display("FAIL resume_block got=%0b/%0b want=1/1", row_valid, row_is_block); end
        checks++; if (row_data !== exp_row) begin fails++; $display("FAIL resume_data got=%h want=%h", row_data, exp_row); end
    endtask

    task automatic test_seed_load_abort;
        int k;
        int exp_cnt;
        do_reset();
        build_stream(16'hACE1, 60);
        k = 5;
        while (!q_blk[k]) k++;
        exp_cnt = 0;
        for (int i = 0; i < k; i++) if (q_blk[i]) exp_cnt++;
        en = 1'b1;
        row_ready = 1'b1;
        tick();
        repeat (k) tick();
        row_ready = 1'b0;
        tick();
        checks++; if (row_valid !== 1'b1 || row_data !== q_data[k]) begin fails++; $display("FAIL abort_pre got=%0b/%h want=1/%h", row_valid, row_data, q_data[k]); end
        seed = 16'h1234;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checks++; if (row_valid !== 1'b0 || row_data !== 8'h00 || row_is_block !== 1'b0) begin fails++; $display("FAIL abort_clear got=%0b/%h/%0b want=0/00/0", row_valid, row_data, row_is_block); end
        checks++; if (blocks_emitted !== 16'(exp_cnt)) begin fails++; $display("FAIL abort_count got=%0d want=%0d", blocks_emitted, exp_cnt); end
        tick();
        checks++; if (row_valid !== 1'b1 || row_is_block !== 1'b1 || row_data !== 8'h34) begin fails++; $display("FAIL abort_restart got=%0b/%0b/%h want=1/1/34", row_valid, row_is_block, row_data); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (row_valid !== 1'b0 || row_data !== 8'h00 || row_is_block !== 1'b0 || blocks_emitted !== 16'h0000) begin fails++; $display("FAIL midblock_reset got=%0b/%h/%0b/%h want=0/00/0/0000", row_valid, row_data, row_is_block, blocks_emitted); end
        tick();
        checks++; if (row_data !== 8'hE1) begin fails++; $display("FAIL post_reset_seed got=%h want=e1", row_data); end
    endtask

    task automatic test_wrap;
        logic [15:0] exp;
        bit saw_zero;
        do_reset();
        build_stream(16'hACE1, 80);
        force dut.r_blocks_emitted = 16'hFFF8;
        #1;
        release dut.r_blocks_emitted;
        checks++; if (blocks_emitted !== 16'hFFF8) begin fails++; $display("FAIL wrap_preset got=%h want=fff8", blocks_emitted); end
        en = 1'b1;
        row_ready = 1'b1;
        tick();
        exp = 16'hFFF8;
        saw_zero = 1'b0;
        for (int i = 0; i < 60; i++) begin
            checks++; if (row_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid row=%0d got=%0b want=1", i, row_valid); end
            checks++; if (blocks_emitted !== exp) begin fails++; $display("FAIL wrap_count row=%0d got=%h want=%h", i, blocks_emitted, exp); end
            if (blocks_emitted == 16'h0000) saw_zero = 1'b1;
            tick();
            if (q_blk[i]) exp = exp + 16'd1;
        end
        checks++; if (saw_zero !== 1'b1) begin fails++; $display("FAIL wrap_zero got=%0b want=1", saw_zero); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;
        row_ready = 1'b0;
        test_reset();
        test_first_rows();
        test_backpressure();
        test_seed_edges();
        test_en_drop_mid_gap();
        test_seed_load_abort();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
